// File: rtl/ss_wb_tgt_model.sv
// ---------------------------------------------------------------------------
// ss_wb_tgt_model
//
// Wishbone target model that sits on the DMA engine's master bus. It answers
// single and consecutive-address (cab) burst cycles from an internal word
// array, and inserts a programmable number of wait states before the first
// beat of each cycle. The bench can inject error terminations on one word
// index and a fixed number of retry terminations at the start of each cycle.
// Acked read/write beats and error terminations are counted for
// scoreboarding.
//
// Ports
//   wb_clk_i        bus clock, rising edge
//   wb_rst_i        asynchronous active-low reset
//   wbs_adr_i       byte address (word index taken from the low bits)
//   wbs_dat_i       write data
//   wbs_sel_i       byte enables, one per lane
//   wbs_we_i        write enable
//   wbs_stb_i       strobe
//   wbs_cyc_i       cycle
//   wbs_cab_i       consecutive-address burst
//   wbs_dat_o       read data, valid during a read ack, 0 otherwise
//   wbs_ack_o       normal termination
//   wbs_err_o       error termination
//   wbs_rty_o       retry termination
//   cfg_wait_i      wait states before the first beat of a cycle
//   cfg_err_en_i    enable error injection
//   cfg_err_idx_i   word index that terminates with err
//   cfg_rty_num_i   retries given at the start of each Wishbone cycle
//   stat_clr_i      synchronous clear of the statistics counters
//   stat_rd_o       acked read beats (saturating)
//   stat_wr_o       acked write beats (saturating)
//   stat_err_o      err terminations (saturating)
// ---------------------------------------------------------------------------
module ss_wb_tgt_model #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT_W = 4,
    parameter int CNT_W  = 16,
    localparam int SW    = DW / 8,
    localparam int IW    = $clog2(DEPTH),
    localparam int LSB   = $clog2(SW)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic [SW-1:0]     wbs_sel_i,
    input  logic              wbs_we_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_cab_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              wbs_rty_o,
    input  logic [WAIT_W-1:0] cfg_wait_i,
    input  logic              cfg_err_en_i,
    input  logic [IW-1:0]     cfg_err_idx_i,
    input  logic [3:0]        cfg_rty_num_i,
    input  logic              stat_clr_i,
    output logic [CNT_W-1:0]  stat_rd_o,
    output logic [CNT_W-1:0]  stat_wr_o,
    output logic [CNT_W-1:0]  stat_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [3:0]          rty_done_q, rty_done_d;
    logic                rty_q, rty_d;
    logic                err_en_q, err_en_d;
    logic [IW-1:0]       err_idx_q, err_idx_d;
    logic [CNT_W-1:0]    stat_rd_q, stat_rd_d;
    logic [CNT_W-1:0]    stat_wr_q, stat_wr_d;
    logic [CNT_W-1:0]    stat_err_q, stat_err_d;

    logic                req;
    logic [IW-1:0]       idx;
    logic                err_hit;
    logic                beat_ok;
    logic                ack;
    logic                err;
    logic                mem_we;
    logic [SW-1:0]       lane_we;
    logic                unused_adr;

    logic [DW-1:0]       mem [DEPTH];

    assign req = wbs_cyc_i & wbs_stb_i;

    // Upper address bits wrap modulo DEPTH; byte-offset bits are ignored.
    assign idx        = wbs_adr_i[IW+LSB-1:LSB];
    assign unused_adr = ^wbs_adr_i;

    // Error injection uses the configuration captured while idle, so a
    // change mid-cycle only affects the next cycle.
    assign err_hit = err_en_q & (idx == err_idx_q);

    // A beat terminates only while the master is actually requesting; this
    // keeps ack/err low whenever cyc or stb are low, even inside RESP/BURST.
    assign beat_ok = req & ((state_q == ST_RESP) |
                            ((state_q == ST_BURST) & wbs_cab_i));
    assign ack     = beat_ok & ~err_hit;
    assign err     = beat_ok &  err_hit;

    assign mem_we  = ack & wbs_we_i;

    for (genvar gi = 0; gi < SW; gi++) begin : g_lane
        assign lane_we[gi] = mem_we & wbs_sel_i[gi];
    end

    // Byte-lane write; the read path below is asynchronous so a read in the
    // beat right after a write to the same index sees the new data.
    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < SW; i++) begin
            if (lane_we[i]) begin
                mem[idx][i*8 +: 8] <= wbs_dat_i[i*8 +: 8];
            end
        end
    end

    function automatic logic [CNT_W-1:0] stat_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cur != '1)) begin
            return cur + CNT_W'(1);
        end
        return cur;
    endfunction

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rty_done_d = rty_done_q;
        rty_d      = 1'b0;
        err_en_d   = err_en_q;
        err_idx_d  = err_idx_q;

        if (state_q == ST_IDLE) begin
            err_en_d  = cfg_err_en_i;
            err_idx_d = cfg_err_idx_i;
        end

        if (!wbs_cyc_i) begin
            // End of the Wishbone cycle: abandon any response and refill
            // the retry budget for the next cycle.
            state_d    = ST_IDLE;
            rty_done_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (rty_done_q < cfg_rty_num_i) begin
                            rty_d      = 1'b1;
                            rty_done_d = rty_done_q + 4'd1;
                        end else begin
                            wcnt_d  = cfg_wait_i;
                            state_d = (cfg_wait_i != '0) ? ST_WAIT : ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    // The last wait cycle is the one where wcnt reads 1.
                    wcnt_d = wcnt_q - WAIT_W'(1);
                    if (wcnt_q <= WAIT_W'(1)) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_d = (ack & wbs_cab_i) ? ST_BURST : ST_IDLE;
                end
                ST_BURST: begin
                    if (!(req & wbs_cab_i) || err_hit) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        stat_rd_d  = stat_next(stat_rd_q,  ack & ~wbs_we_i, stat_clr_i);
        stat_wr_d  = stat_next(stat_wr_q,  ack &  wbs_we_i, stat_clr_i);
        stat_err_d = stat_next(stat_err_q, err,             stat_clr_i);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            rty_done_q <= 4'd0;
            rty_q      <= 1'b0;
            err_en_q   <= 1'b0;
            err_idx_q  <= '0;
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rty_done_q <= rty_done_d;
            rty_q      <= rty_d;
            err_en_q   <= err_en_d;
            err_idx_q  <= err_idx_d;
            stat_rd_q  <= stat_rd_d;
            stat_wr_q  <= stat_wr_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign wbs_ack_o  = ack;
    assign wbs_err_o  = err;
    assign wbs_rty_o  = rty_q & wbs_cyc_i;
    assign wbs_dat_o  = (ack & ~wbs_we_i) ? mem[idx] : '0;

    assign stat_rd_o  = stat_rd_q;
    assign stat_wr_o  = stat_wr_q;
    assign stat_err_o = stat_err_q;

endmodule

// File: tb/tb_ss_wb_tgt_model.sv
// ---------------------------------------------------------------------------
// tb_ss_wb_tgt_model
//
// Directed bench for ss_wb_tgt_model. Expected read data is pushed onto a
// scoreboard queue when a read is issued and popped when the target acks.
// Expected statistics and latencies come from the bench's own bookkeeping.
// ---------------------------------------------------------------------------
module tb_ss_wb_tgt_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we, stb, cyc, cab;
    logic [31:0] dat_o;
    logic        ack, err, rty;
    logic [3:0]  cfg_wait;
    logic        cfg_err_en;
    logic [9:0]  cfg_err_idx;
    logic [3:0]  cfg_rty_num;
    logic        stat_clr;
    logic [15:0] stat_rd, stat_wr, stat_err;

    int checks   = 0;
    int failures = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;
    int exp_err  = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ss_wb_tgt_model dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat_i),
        .wbs_sel_i     (sel),
        .wbs_we_i      (we),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_cab_i     (cab),
        .wbs_dat_o     (dat_o),
        .wbs_ack_o     (ack),
        .wbs_err_o     (err),
        .wbs_rty_o     (rty),
        .cfg_wait_i    (cfg_wait),
        .cfg_err_en_i  (cfg_err_en),
        .cfg_err_idx_i (cfg_err_idx),
        .cfg_rty_num_i (cfg_rty_num),
        .stat_clr_i    (stat_clr),
        .stat_rd_o     (stat_rd),
        .stat_wr_o     (stat_wr),
        .stat_err_o    (stat_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, dat_o, e);
        end
    endtask

    task automatic chk_stats(input string tag);
        check({tag, "_stat_rd"},  {16'd0, stat_rd},  32'(exp_rd));
        check({tag, "_stat_wr"},  {16'd0, stat_wr},  32'(exp_wr));
        check({tag, "_stat_err"}, {16'd0, stat_err}, 32'(exp_err));
    endtask

    // One Wishbone cycle with a single beat; the master holds stb through
    // retries. Called and returns one time unit after a rising edge.
    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int lat, output int n_rty,
                            output logic got_err);
        logic done;
        cyc = 1'b1; stb = 1'b1; cab = 1'b0; we = w; adr = a; dat_i = d; sel = s;
        lat = 0; n_rty = 0; got_err = 1'b0; done = 1'b0;
        while (!done && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (rty) begin
                n_rty++;
            end else if (err) begin
                got_err = 1'b1;
                done    = 1'b1;
            end else if (ack) begin
                done = 1'b1;
                if (!w) sb_check("rdata");
            end
        end
        check("term_seen", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        int lat, nr;
        logic ge;
        wb_cycle(1'b1, a, d, s, lat, nr, ge);
        check({tag, "_lat"}, 32'(lat), 32'(1 + cfg_wait));
        check({tag, "_err_rty"}, 32'({ge, 8'(nr)}), 32'd0);
        exp_wr++;
        $display("WR  %s adr=%h dat=%h sel=%h lat=%0d", tag, a, d, s, lat);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        int lat, nr;
        logic ge;
        exp_q.push_back(e);
        wb_cycle(1'b0, a, 32'd0, 4'hF, lat, nr, ge);
        check({tag, "_lat"}, 32'(lat), 32'(1 + cfg_wait));
        check({tag, "_err_rty"}, 32'({ge, 8'(nr)}), 32'd0);
        exp_rd++;
        $display("RD  %s adr=%h exp=%h lat=%0d", tag, a, e, lat);
    endtask

    // cab burst of n beats from base; write data is beat number + 1.
    task automatic wb_burst(input logic w, input logic [31:0] base, input int n,
                            output int first_lat, output int n_consec);
        int   k, cnt, prev;
        logic acked;
        cyc = 1'b1; stb = 1'b1; cab = 1'b1; we = w; sel = 4'hF; adr = base; dat_i = 32'd1;
        k = 0; cnt = 0; prev = 0; acked = 1'b0; first_lat = 0; n_consec = 0;
        while (cnt < 200) begin
            @(posedge clk); #1;
            if (acked) begin
                k++;
                adr   = base + 32'(4 * k);
                dat_i = 32'(k + 1);
            end
            if (k == n) break;
            @(negedge clk);
            cnt++;
            acked = ack;
            if (ack) begin
                if (k == 0) first_lat = cnt;
                else if (cnt == prev + 1) n_consec++;
                prev = cnt;
                if (!w) sb_check("burst_rdata");
            end
        end
        check("burst_beats", 32'(k), 32'(n));
        cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int   lat, nr, fl, nc;
        logic ge, seen;

        rst_n = 1'b0;
        adr = '0; dat_i = '0; sel = '0; we = 0; stb = 0; cyc = 0; cab = 0;
        cfg_wait = 4'd0; cfg_err_en = 1'b0; cfg_err_idx = '0; cfg_rty_num = 4'd0;
        stat_clr = 1'b0;

        // Reset state
        #12;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rty", {31'd0, rty}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        chk_stats("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single write then read, no wait states
        wr(32'h10, 32'hA5A5_1234, 4'hF, "t1_wr");
        chk_stats("t1a");
        rd(32'h10, 32'hA5A5_1234, "t1_rd");
        chk_stats("t1b");
        // Address wraps modulo DEPTH words
        rd(32'h1010, 32'hA5A5_1234, "t1_wrap");

        // 2: three wait states
        wr(32'h20, 32'h5555_AAAA, 4'hF, "t2_wr");
        cfg_wait = 4'd3;
        rd(32'h20, 32'h5555_AAAA, "t2_rd");

        // Clear statistics before the burst section
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        chk_stats("clr");

        // 3: 8-beat bursts with two wait states
        cfg_wait = 4'd2;
        wb_burst(1'b1, 32'h100, 8, fl, nc);
        exp_wr += 8;
        check("t3_wr_first_lat", 32'(fl), 32'd3);
        check("t3_wr_consec", 32'(nc), 32'd7);
        $display("BWR adr=%h beats=8 first_lat=%0d consec=%0d", 32'h100, fl, nc);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        wb_burst(1'b0, 32'h100, 8, fl, nc);
        exp_rd += 8;
        check("t3_rd_first_lat", 32'(fl), 32'd3);
        check("t3_rd_consec", 32'(nc), 32'd7);
        $display("BRD adr=%h beats=8 first_lat=%0d consec=%0d", 32'h100, fl, nc);
        chk_stats("t3");

        // 4: byte enables
        cfg_wait = 4'd0;
        wr(32'h40, 32'hFFFF_FFFF, 4'hF, "t4_wr_ones");
        wr(32'h40, 32'h0000_0000, 4'h5, "t4_wr_sel5");
        rd(32'h40, 32'hFF00_FF00, "t4_rd");
        // Clear held across an ack: clear wins
        stat_clr = 1'b1;
        rd(32'h40, 32'hFF00_FF00, "t4_rd_clr");
        stat_clr = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        chk_stats("t4_clr");

        // 5: error injection on word 5
        cfg_err_en = 1'b1; cfg_err_idx = 10'd5;
        wb_cycle(1'b0, 32'h14, 32'd0, 4'hF, lat, nr, ge);
        exp_err++;
        check("t5_err_flag", {31'd0, ge}, 32'd1);
        check("t5_err_lat", 32'(lat), 32'd1);
        $display("ERR adr=%h lat=%0d err=%0b", 32'h14, lat, ge);
        chk_stats("t5_err");
        cfg_err_en = 1'b0;

        // Retry injection, budget renewed per Wishbone cycle
        cfg_rty_num = 4'd2;
        for (int rep = 0; rep < 2; rep++) begin
            exp_q.push_back(32'hA5A5_1234);
            wb_cycle(1'b0, 32'h10, 32'd0, 4'hF, lat, nr, ge);
            exp_rd++;
            check("t5_rty_count", 32'(nr), 32'd2);
            check("t5_rty_lat", 32'(lat), 32'd3);
            $display("RTY adr=%h rep=%0d rty=%0d lat=%0d", 32'h10, rep, nr, lat);
        end
        cfg_rty_num = 4'd0;
        chk_stats("t5_rty");

        // 6: drop cyc during wait states of a write
        cfg_wait = 4'd5;
        cyc = 1'b1; stb = 1'b1; cab = 1'b0; we = 1'b1; adr = 32'h40;
        dat_i = 32'h1234_5678; sel = 4'hF;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (ack || err || rty) seen = 1'b1;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("t6_abort_no_term", {31'd0, seen}, 32'd0);
        $display("ABT adr=%h term_seen=%0b", 32'h40, seen);
        cfg_wait = 4'd0;
        rd(32'h40, 32'hFF00_FF00, "t6_abort_rd");
        chk_stats("t6_abort");

        // Asynchronous reset in the middle of a read burst
        cyc = 1'b1; stb = 1'b1; cab = 1'b1; we = 1'b0; adr = 32'h100; sel = 4'hF;
        @(posedge clk); @(negedge clk);
        check("t6_pre_rst_ack", {31'd0, ack}, 32'd1);
        check("t6_pre_rst_dat", dat_o, 32'd1);
        @(posedge clk); #1;
        adr = 32'h104;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack", {31'd0, ack}, 32'd0);
        check("t6_rst_err", {31'd0, err}, 32'd0);
        check("t6_rst_rty", {31'd0, rty}, 32'd0);
        check("t6_rst_dat", dat_o, 32'd0);
        $display("RST mid-burst adr=%h", 32'h104);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cab = 1'b0;
        rst_n = 1'b1;
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        chk_stats("t6_rst");
        @(posedge clk); #1;
        rd(32'h100, 32'd1, "t6_keep0");
        rd(32'h11C, 32'd8, "t6_keep7");
        rd(32'h10, 32'hA5A5_1234, "t6_keep_single");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_wb_tgt_model.md
Name: ss_wb_tgt_model

Overview:
- Parametrised Wishbone target model for the ADMA environment, placed on the DMA engine's master bus (wbm_*).
- Answers single and burst (cab) read/write cycles from an internal word-array memory.
- Inserts a programmable number of wait states.
- Injects errors and retries under control of the bench.
- Keeps read/write/error beat counters for scoreboarding.

Parameters:
DW, 32, data width in bits; multiple of 8. SW = DW/8 byte lanes.
AW, 32, address width.
DEPTH, 1024, memory words; power of two. IW = log2(DEPTH).
WAIT_W, 4, width of the wait-state configuration.
CNT_W, 16, width of the statistics counters.

Ports:
wb_clk_i  in  1  bus clock; all logic on the rising edge.
wb_rst_i  in  1  asynchronous, active-low reset.
wbs_adr_i  in  AW  byte address.
wbs_dat_i  in  DW  write data.
wbs_sel_i  in  SW  byte enables.
wbs_we_i  in  1  write enable.
wbs_stb_i  in  1  strobe.
wbs_cyc_i  in  1  cycle.
wbs_cab_i  in  1  consecutive-address burst.
wbs_dat_o  out  DW  read data.
wbs_ack_o  out  1  acknowledge.
wbs_err_o  out  1  error termination.
wbs_rty_o  out  1  retry termination.
cfg_wait_i  in  WAIT_W  wait states inserted before the first beat of a cycle.
cfg_err_en_i  in  1  enable error injection.
cfg_err_idx_i  in  IW  word index that returns err.
cfg_rty_num_i  in  4  number of rty responses given at the start of each cycle.
stat_clr_i  in  1  synchronous clear of the statistics counters.
stat_rd_o  out  CNT_W  acked read beats.
stat_wr_o  out  CNT_W  acked write beats.
stat_err_o  out  CNT_W  err terminations.

Behaviour:
- Reset (wb_rst_i low, asynchronous):
  - ack, err and rty are 0; wbs_dat_o is 0; the FSM is in IDLE.
  - All counters (wait, retry, statistics) are 0.
  - Memory contents are not reset.
- Word index: idx = wbs_adr_i[IW+log2(SW)-1 : log2(SW)]. Addresses above DEPTH wrap modulo DEPTH; there is no error for out-of-range addresses.
- Request: req = wbs_cyc_i & wbs_stb_i.
- FSM states: IDLE, WAIT, RESP, BURST.
- IDLE:
  - On req with rty_done < cfg_rty_num_i: assert rty for one cycle in the next cycle, increment rty_done, stay in IDLE.
  - Otherwise on req: load wcnt = cfg_wait_i. Go to WAIT if cfg_wait_i != 0, else go to RESP.
- WAIT: decrement wcnt each cycle; go to RESP when wcnt reaches 1.
- RESP: one termination cycle.
  - If cfg_err_en_i and idx == cfg_err_idx_i: err = 1, no memory write, stat_err increments.
  - Otherwise ack = 1.
    - Write: for each lane i with sel[i] = 1, mem[idx] byte i takes dat_i byte i.
    - Read: wbs_dat_o = mem[idx], combinational on the current address during the ack cycle; 0 when ack is low.
  - Next state: BURST if wbs_cab_i & req & ack; otherwise IDLE.
- BURST:
  - ack is high in every cycle where req & wbs_cab_i hold. There are no wait states after the first beat.
  - The master presents a new address after each acked beat.
  - The error check applies per beat; an err beat ends the burst and returns to IDLE.
  - Return to IDLE when stb or cab drops.
- Termination rules:
  - Latency from the first req to the first termination is 1 + cfg_wait_i cycles.
  - ack, err and rty are mutually exclusive and never asserted while cyc is low.
- wbs_cyc_i low in any state:
  - Return to IDLE on the next edge with no write.
  - rty_done clears to 0, so the retry budget applies per Wishbone cycle.
- A write and a read of the same index in back-to-back beats: the read returns the newly written data.
- Statistics:
  - Counters saturate at all-ones.
  - stat_clr_i has priority over a simultaneous increment; the result is 0.
- Configuration inputs are sampled only in IDLE; changes during a cycle take effect on the next cycle.

Test Plan:
1. Reset, then single write: cfg_wait=0, adr=0x10, dat=0xA5A5_1234, sel=0xF.
   -> ack exactly 1 cycle after req; stat_wr=1.
   -> A following read of 0x10 returns 0xA5A5_1234; stat_rd=1.
2. cfg_wait=3, single read of 0x20 -> ack in the 4th cycle after req; ack low in cycles 1-3; err and rty low throughout.
3. Burst write of 8 beats with cab=1 from 0x100, cfg_wait=2, data 1..8.
   -> First ack after 3 cycles, then 7 consecutive acks.
   -> A burst read returns 1..8; stat_wr=8.
4. Byte enables: write 0xFFFFFFFF to 0x40, then write 0x00000000 with sel=0x5 -> a read of 0x40 returns 0xFF00FF00.
5. Error and retry injection:
   - cfg_err_en=1, cfg_err_idx=5, read of 0x14 -> err in 1 cycle, no ack; stat_err=1.
   - cfg_rty_num=2 -> two rty responses, then ack on the third attempt within the same cyc.
   - Drop cyc and restart -> rty is given twice again.
6. Abort and reset:
   - Drop cyc during WAIT with cfg_wait=5 on a write -> no ack and memory unchanged.
   - Assert wb_rst_i low mid-burst -> all outputs are 0 immediately (asynchronously); memory data written before the reset is still readable afterwards.
